// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - screen geometry, framebuffer placement and memory read-port constants
package chip8_pkg;

    localparam logic [11:0] FB_BASE_DEFAULT = 12'h100;
    localparam int          SCREEN_W        = 64;
    localparam int          SCREEN_H        = 32;
    localparam int          FB_BYTES        = SCREEN_W * SCREEN_H / 8;

    // Read port: request held until a one-cycle ack, earliest one cycle after the request rises
    localparam int          MEM_ADDR_W      = 12;
    localparam int          MEM_DATA_W      = 8;
    localparam int          MEM_ACK_MIN_LAT = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// rtl/fb_prefetch_fifo.sv - two-entry byte FIFO buffering fetched framebuffer bytes
module fb_prefetch_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    logic [7:0] slot [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slot[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - fetches the monochrome framebuffer and streams it out in raster order
module fb_scanout
    import chip8_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] FB_BASE = FB_BASE_DEFAULT,
    parameter int                    WIDTH   = SCREEN_W,
    parameter int                    HEIGHT  = SCREEN_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_read_idx,
    input  logic [MEM_DATA_W-1:0] mem_read_byte,
    input  logic                  mem_read_ack,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic [5:0]            pix_x,
    output logic [4:0]            pix_y,
    output logic                  pix_last
);

    localparam int unsigned BPR    = WIDTH / 8;
    localparam int unsigned NBYTES = WIDTH * HEIGHT / 8;
    localparam int          FIDX_W = $clog2(NBYTES + 1);

    scan_state_t       state;
    scan_state_t       state_next;
    logic [FIDX_W-1:0] fidx;
    logic [FIDX_W-1:0] fidx_next;
    logic [FIDX_W-1:0] load_idx;
    logic [FIDX_W-1:0] cur_byte;
    logic [7:0]        shifter;
    logic [7:0]        load_byte;
    logic [7:0]        fifo_dout;
    logic [2:0]        bit_cnt;
    logic [1:0]        fifo_cnt;
    logic [1:0]        fifo_cnt_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              ack_ok;
    logic              accept;
    logic              last_bit;
    logic              need_load;
    logic              bypass;
    logic              load;
    logic              start_ok;

    assign ack_ok    = mem_read && mem_read_ack;
    assign accept    = pix_valid && pix_ready;
    assign last_bit  = (bit_cnt == 3'd7);
    assign need_load = !pix_valid || (accept && last_bit);
    assign start_ok  = (state == ST_IDLE) && start;

    // An ack arriving while the shifter wants a byte and the FIFO is empty goes straight in
    assign bypass    = need_load && fifo_empty && ack_ok;
    assign fifo_pop  = need_load && !fifo_empty;
    assign fifo_push = ack_ok && !bypass;
    assign load      = fifo_pop || bypass;
    assign load_byte = fifo_empty ? mem_read_byte : fifo_dout;

    assign fifo_cnt      = {fifo_full, !fifo_full && !fifo_empty};
    assign fifo_cnt_next = fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
    assign fidx_next     = start_ok ? '0 : fidx + {{(FIDX_W-1){1'b0}}, ack_ok};

    assign mem_read_idx = mem_read ? FB_BASE + MEM_ADDR_W'(fidx) : '0;
    assign pix_data     = shifter[7];
    assign pix_x        = 6'((32'(cur_byte) % BPR) * 32'd8 + 32'(bit_cnt));
    assign pix_y        = 5'(32'(cur_byte) / BPR);

    fb_prefetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (mem_read_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        pix_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy     = 1'b1;
                pix_last = pix_valid && last_bit && (cur_byte == FIDX_W'(NBYTES - 1));
                if (accept && pix_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fidx <= '0;
        else        fidx <= fidx_next;
    end

    // A new request needs a FIFO slot reserved for its data, so count what the FIFO holds after this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read <= 1'b0;
        end else if (mem_read && !mem_read_ack) begin
            mem_read <= 1'b1;
        end else begin
            mem_read <= (state_next == ST_RUN) && (fidx_next < FIDX_W'(NBYTES))
                        && (fifo_cnt_next < 2'd2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            shifter   <= '0;
            bit_cnt   <= '0;
            cur_byte  <= '0;
            load_idx  <= '0;
        end else if (start_ok) begin
            load_idx <= '0;
        end else if (load) begin
            pix_valid <= 1'b1;
            shifter   <= load_byte;
            bit_cnt   <= '0;
            cur_byte  <= load_idx;
            load_idx  <= load_idx + FIDX_W'(1);
        end else if (accept) begin
            shifter <= {shifter[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) pix_valid <= 1'b0;
        end
    end

endmodule
